// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: states, opcodes, ALU ops, bit indices, control vector.
// Optional mul/div decode is enabled by defining CU_MULDIV_EN.
package cu_pkg;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } cuState_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_DIV  = 4'd6;

  localparam int EN_HI    = 16;
  localparam int EN_LO    = 17;
  localparam int EN_Z     = 18;
  localparam int EN_Y     = 19;
  localparam int EN_PC    = 20;
  localparam int EN_MDR   = 21;
  localparam int EN_IR    = 24;
  localparam int EN_MAR   = 25;
  localparam int EN_INCPC = 27;

  localparam int BS_R0     = 0;
  localparam int BS_HI     = 16;
  localparam int BS_LO     = 17;
  localparam int BS_ZHI    = 18;
  localparam int BS_ZLO    = 19;
  localparam int BS_PC     = 20;
  localparam int BS_MDR    = 21;
  localparam int BS_INPORT = 22;
  localparam int BS_C      = 23;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LD, CLS_LDI, CLS_ST, CLS_MULDIV, CLS_HALT
  } instrClass_t;

  typedef struct packed {
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic [4:0]  controlSignals;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        baOut;
    logic        mdRead;
    logic        readRam;
    logic        writeRam;
    logic        run;
  } ctrlVec_t;

  // Anything not recognised executes as nop, so the FSM never stalls on a bad opcode.
  function automatic instrClass_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_ALU;
      OP_LD:                         return CLS_LD;
      OP_LDI:                        return CLS_LDI;
      OP_ST:                         return CLS_ST;
      OP_HALT:                       return CLS_HALT;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                return CLS_MULDIV;
`endif
      default:                       return CLS_NOP;
    endcase
  endfunction

  function automatic logic [3:0] aluOpOf(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cu_if.sv
// Bundle between the control unit and the datapath: instruction in, control strobes out.
interface cu_if;
  logic [31:0] ir;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [4:0]  Control_Signals;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        MD_Read, ReadRAM, WriteRAM;
  logic        run;

  modport master (
    input  ir,
    output enable, busSelect, Control_Signals,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output MD_Read, ReadRAM, WriteRAM, run
  );

  modport slave (
    output ir,
    input  enable, busSelect, Control_Signals,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  MD_Read, ReadRAM, WriteRAM, run
  );
endinterface

// File: rtl/cu_outdec.sv
// Purely combinational Moore output decode: (state, latched opcode) -> control vector.
module cu_outdec
  import cu_pkg::*;
(
  input  cuState_t   state,
  input  logic [4:0] opcode,
  output ctrlVec_t   ctrl
);

  instrClass_t cls;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    ctrl = '0;
    cls  = classify(opcode);
    ctrl.run = !(state inside {RST, HALT});

    case (state)
      T0: begin
        ctrl.busSelect[BS_PC]   = 1'b1;
        ctrl.enable[EN_MAR]     = 1'b1;
        ctrl.enable[EN_INCPC]   = 1'b1;
      end
      T1: begin
        ctrl.readRam            = 1'b1;
        ctrl.mdRead             = 1'b1;
        ctrl.enable[EN_MDR]     = 1'b1;
      end
      T2: begin
        ctrl.busSelect[BS_MDR]  = 1'b1;
        ctrl.enable[EN_IR]      = 1'b1;
      end
      T3: begin
        case (cls)
          CLS_ALU:                 begin ctrl.grb = 1'b1; ctrl.rout  = 1'b1; ctrl.enable[EN_Y] = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin ctrl.grb = 1'b1; ctrl.baOut = 1'b1; ctrl.enable[EN_Y] = 1'b1; end
          CLS_MULDIV:              begin ctrl.gra = 1'b1; ctrl.rout  = 1'b1; ctrl.enable[EN_Y] = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_ALU: begin
            ctrl.grc = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.controlSignals = {1'b0, aluOpOf(opcode)};
            ctrl.enable[EN_Z] = 1'b1;
          end
          CLS_LD, CLS_LDI, CLS_ST: begin
            ctrl.busSelect[BS_C] = 1'b1;
            ctrl.controlSignals = {1'b0, ALU_ADD};
            ctrl.enable[EN_Z] = 1'b1;
          end
          CLS_MULDIV: begin
            ctrl.grb = 1'b1;
            ctrl.rout = 1'b1;
            ctrl.controlSignals = {1'b0, aluOpOf(opcode)};
            ctrl.enable[EN_Z] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_ALU, CLS_LDI: begin ctrl.busSelect[BS_ZLO] = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          CLS_LD, CLS_ST:   begin ctrl.busSelect[BS_ZLO] = 1'b1; ctrl.enable[EN_MAR] = 1'b1; end
          CLS_MULDIV:       begin ctrl.busSelect[BS_ZLO] = 1'b1; ctrl.enable[EN_LO] = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD:     begin ctrl.readRam = 1'b1; ctrl.mdRead = 1'b1; ctrl.enable[EN_MDR] = 1'b1; end
          CLS_ST:     begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.writeRam = 1'b1; end
          CLS_MULDIV: begin ctrl.busSelect[BS_ZHI] = 1'b1; ctrl.enable[EN_HI] = 1'b1; end
          default: ;
        endcase
      end
      T7: begin
        if (cls == CLS_LD) begin
          ctrl.busSelect[BS_MDR] = 1'b1;
          ctrl.gra = 1'b1;
          ctrl.rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Control unit top: state register, opcode latch and next-state logic; outputs come from cu_outdec.
// Defining CU_MULDIV_EN adds the mul/div sequences (decoded in cu_pkg::classify).
module control_unit
  import cu_pkg::*;
(
  input logic clk,
  input logic clr,
  cu_if.master cuBus
);

  cuState_t    state, nextState;
  logic [4:0]  opcode;
  instrClass_t cls;
  ctrlVec_t    ctrl;
  logic        unusedIrBits;

  assign unusedIrBits = ^cuBus.ir[26:0];

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= RST;
      opcode <= OP_NOP;
    end else begin
      state <= nextState;
      if (state == T2) opcode <= cuBus.ir[31:27];
    end
  end

  always_comb begin
    nextState = state;
    cls       = classify(opcode);
    case (state)
      RST:  nextState = T0;
      T0:   nextState = T1;
      T1:   nextState = T2;
      T2:   nextState = T3;
      T3: begin
        case (cls)
          CLS_NOP:  nextState = T0;
          CLS_HALT: nextState = HALT;
          default:  nextState = T4;
        endcase
      end
      T4:   nextState = T5;
      T5:   nextState = (cls inside {CLS_LD, CLS_ST, CLS_MULDIV}) ? T6 : T0;
      T6:   nextState = (cls == CLS_LD) ? T7 : T0;
      T7:   nextState = T0;
      HALT: nextState = HALT;
      default: nextState = RST;
    endcase
  end

  cu_outdec u_outdec (
    .state  (state),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign cuBus.enable          = ctrl.enable;
  assign cuBus.busSelect       = ctrl.busSelect;
  assign cuBus.Control_Signals = ctrl.controlSignals;
  assign cuBus.Gra             = ctrl.gra;
  assign cuBus.Grb             = ctrl.grb;
  assign cuBus.Grc             = ctrl.grc;
  assign cuBus.Rin             = ctrl.rin;
  assign cuBus.Rout            = ctrl.rout;
  assign cuBus.BAout           = ctrl.baOut;
  assign cuBus.MD_Read         = ctrl.mdRead;
  assign cuBus.ReadRAM         = ctrl.readRam;
  assign cuBus.WriteRAM        = ctrl.writeRam;
  assign cuBus.run             = ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle vector table through a scoreboard, plus latency sequences.
module tb_control_unit;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic clr;
  cu_if cuBus ();

  control_unit dut (
    .clk   (clk),
    .clr   (clr),
    .cuBus (cuBus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] B_ZHI = 32'h0004_0000;
  localparam logic [31:0] B_ZLO = 32'h0008_0000;
  localparam logic [31:0] B_PC  = 32'h0010_0000;
  localparam logic [31:0] B_MDR = 32'h0020_0000;
  localparam logic [31:0] B_C   = 32'h0080_0000;

  localparam logic [31:0] E_HI  = 32'h0001_0000;
  localparam logic [31:0] E_LO  = 32'h0002_0000;
  localparam logic [31:0] E_Z   = 32'h0004_0000;
  localparam logic [31:0] E_Y   = 32'h0008_0000;
  localparam logic [31:0] E_MDR = 32'h0020_0000;
  localparam logic [31:0] E_IR  = 32'h0100_0000;
  localparam logic [31:0] E_MAR = 32'h0200_0000;
  localparam logic [31:0] E_INC = 32'h0800_0000;

  // Strobe field order: Gra Grb Grc Rin Rout BAout MD_Read ReadRAM WriteRAM run
  localparam logic [9:0] S_GRA  = 10'h200;
  localparam logic [9:0] S_GRB  = 10'h100;
  localparam logic [9:0] S_GRC  = 10'h080;
  localparam logic [9:0] S_RIN  = 10'h040;
  localparam logic [9:0] S_ROUT = 10'h020;
  localparam logic [9:0] S_BA   = 10'h010;
  localparam logic [9:0] S_MDRD = 10'h008;
  localparam logic [9:0] S_RRAM = 10'h004;
  localparam logic [9:0] S_WRAM = 10'h002;
  localparam logic [9:0] S_RUN  = 10'h001;

  typedef struct {
    string       name;
    logic        clr;
    logic [4:0]  op;
    logic [78:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [78:0] sb[$];
  int          tests  = 0;
  int          failed = 0;
  logic        sawHiLo = 1'b0;

  function automatic logic [78:0] e(input logic [31:0] bus, input logic [31:0] en,
                                    input logic [3:0] alu, input logic [9:0] s);
    return {bus, en, 1'b0, alu, s};
  endfunction

  function automatic logic [78:0] actual();
    return {cuBus.busSelect, cuBus.enable, cuBus.Control_Signals,
            cuBus.Gra, cuBus.Grb, cuBus.Grc, cuBus.Rin, cuBus.Rout, cuBus.BAout,
            cuBus.MD_Read, cuBus.ReadRAM, cuBus.WriteRAM, cuBus.run};
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] op);
    return {op, 4'd5, 4'd6, 4'd7, 15'd0};
  endfunction

  function automatic logic isT0();
    return (cuBus.busSelect == B_PC) && (cuBus.enable == (E_MAR | E_INC));
  endfunction

  task automatic check(input string name, input logic [78:0] act, input logic [78:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic c, input logic [4:0] op, input logic [78:0] ex);
    vecs.push_back('{n, c, op, ex});
  endtask

  task automatic addFetch(input string n, input logic [4:0] op);
    add({n, "_T0"}, 1'b0, op, e(B_PC, E_MAR | E_INC, ALU_NONE, S_RUN));
    add({n, "_T1"}, 1'b0, op, e('0, E_MDR, ALU_NONE, S_MDRD | S_RRAM | S_RUN));
    add({n, "_T2"}, 1'b0, op, e(B_MDR, E_IR, ALU_NONE, S_RUN));
  endtask

  task automatic addLdHead(input string n, input logic [4:0] op);
    add({n, "_T3"}, 1'b0, op, e('0, E_Y, ALU_NONE, S_GRB | S_BA | S_RUN));
    add({n, "_T4"}, 1'b0, op, e(B_C, E_Z, ALU_ADD, S_RUN));
  endtask

  task automatic addNop(input string n, input logic [4:0] op);
    addFetch(n, op);
    add({n, "_T3"}, 1'b0, op, e('0, '0, ALU_NONE, S_RUN));
  endtask

  task automatic measureLatency(input string n, input logic [4:0] op, input int expCycles);
    int cycles;
    cuBus.ir = mkIr(op);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    check({n, "_startT0"}, {78'd0, isT0()}, 79'd1);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!isT0() && cycles < 20);
    check({n, "_latency"}, 79'(cycles), 79'(expCycles));
  endtask

  logic [4:0] aluOps[4]   = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
  logic [3:0] aluCodes[4] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
  string      aluNames[4] = '{"add", "sub", "and", "or"};

  initial begin
    clr = 1'b1;
    cuBus.ir = '0;

    add("rst", 1'b0, OP_ADD, e('0, '0, ALU_NONE, '0));
    for (int i = 0; i < 4; i++) begin
      addFetch(aluNames[i], aluOps[i]);
      add({aluNames[i], "_T3"}, 1'b0, aluOps[i], e('0, E_Y, ALU_NONE, S_GRB | S_ROUT | S_RUN));
      add({aluNames[i], "_T4"}, 1'b0, aluOps[i], e('0, E_Z, aluCodes[i], S_GRC | S_ROUT | S_RUN));
      add({aluNames[i], "_T5"}, 1'b0, aluOps[i], e(B_ZLO, '0, ALU_NONE, S_GRA | S_RIN | S_RUN));
    end

    addFetch("ld", OP_LD);
    addLdHead("ld", OP_LD);
    add("ld_T5", 1'b0, OP_LD, e(B_ZLO, E_MAR, ALU_NONE, S_RUN));
    add("ld_T6", 1'b0, OP_LD, e('0, E_MDR, ALU_NONE, S_MDRD | S_RRAM | S_RUN));
    add("ld_T7", 1'b0, OP_LD, e(B_MDR, '0, ALU_NONE, S_GRA | S_RIN | S_RUN));

    addFetch("ldi", OP_LDI);
    addLdHead("ldi", OP_LDI);
    add("ldi_T5", 1'b0, OP_LDI, e(B_ZLO, '0, ALU_NONE, S_GRA | S_RIN | S_RUN));

    addFetch("st", OP_ST);
    addLdHead("st", OP_ST);
    add("st_T5", 1'b0, OP_ST, e(B_ZLO, E_MAR, ALU_NONE, S_RUN));
    add("st_T6", 1'b0, OP_ST, e('0, '0, ALU_NONE, S_GRA | S_ROUT | S_WRAM | S_RUN));

    addNop("nop", OP_NOP);
    addNop("unlisted", 5'b11111);

`ifdef CU_MULDIV_EN
    addFetch("mul", OP_MUL);
    add("mul_T3", 1'b0, OP_MUL, e('0, E_Y, ALU_NONE, S_GRA | S_ROUT | S_RUN));
    add("mul_T4", 1'b0, OP_MUL, e('0, E_Z, ALU_MUL, S_GRB | S_ROUT | S_RUN));
    add("mul_T5", 1'b0, OP_MUL, e(B_ZLO, E_LO, ALU_NONE, S_RUN));
    add("mul_T6", 1'b0, OP_MUL, e(B_ZHI, E_HI, ALU_NONE, S_RUN));
    addFetch("div", OP_DIV);
    add("div_T3", 1'b0, OP_DIV, e('0, E_Y, ALU_NONE, S_GRA | S_ROUT | S_RUN));
    add("div_T4", 1'b0, OP_DIV, e('0, E_Z, ALU_DIV, S_GRB | S_ROUT | S_RUN));
    add("div_T5", 1'b0, OP_DIV, e(B_ZLO, E_LO, ALU_NONE, S_RUN));
    add("div_T6", 1'b0, OP_DIV, e(B_ZHI, E_HI, ALU_NONE, S_RUN));
`else
    addNop("mul", OP_MUL);
    addNop("div", OP_DIV);
`endif

    addNop("halt", OP_HALT);
    for (int i = 0; i < 20; i++) add("halt_hold", 1'b0, OP_HALT, e('0, '0, ALU_NONE, '0));
    add("halt_clr", 1'b1, OP_LD, e('0, '0, ALU_NONE, '0));
    add("halt_rst", 1'b0, OP_LD, e('0, '0, ALU_NONE, '0));

    addFetch("ldabort", OP_LD);
    addLdHead("ldabort", OP_LD);
    add("ldabort_T5", 1'b1, OP_LD, e(B_ZLO, E_MAR, ALU_NONE, S_RUN));
    add("ldabort_rst", 1'b0, OP_LD, e('0, '0, ALU_NONE, '0));
    add("ldabort_T0", 1'b0, OP_LD, e(B_PC, E_MAR | E_INC, ALU_NONE, S_RUN));

    @(posedge clk);
    @(posedge clk);
    foreach (vecs[i]) begin
      #1;
      clr = vecs[i].clr;
      cuBus.ir = mkIr(vecs[i].op);
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      check(vecs[i].name, actual(), sb.pop_front());
      check({vecs[i].name, "_onehot"}, 79'($countones(cuBus.busSelect) <= 1), 79'd1);
      if (cuBus.enable[17:16] != 2'b00) sawHiLo = 1'b1;
      @(posedge clk);
    end

`ifndef CU_MULDIV_EN
    check("hilo_never_set", {78'd0, sawHiLo}, 79'd0);
`endif

    measureLatency("add", OP_ADD, 6);
    measureLatency("ldi", OP_LDI, 6);
    measureLatency("ld", OP_LD, 8);
    measureLatency("st", OP_ST, 7);
    measureLatency("nop", OP_NOP, 4);
`ifdef CU_MULDIV_EN
    measureLatency("mul", OP_MUL, 7);
`else
    measureLatency("mul", OP_MUL, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
